// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_if
// Description : Control and status bundle between tick source, controls and
//               the countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_if;
   logic       tick;
   logic       load;
   logic [7:0] load_min;
   logic [7:0] load_sec;
   logic       start_stop;
   logic       clear;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       running;
   logic       alarm;
   logic       done;

   modport master (
      output tick, load, load_min, load_sec, start_stop, clear,
      input  min_bcd, sec_bcd, running, alarm, done
   );

   modport slave (
      input  tick, load, load_min, load_sec, start_stop, clear,
      output min_bcd, sec_bcd, running, alarm, done
   );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : BCD mm:ss countdown driven by tick pulses, with timed alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
   parameter int TICKS_PER_SEC = 10,
   parameter int SUB_WIDTH     = 4,
   parameter int ALARM_SECS    = 10
) (
   input  wire               clk,
   input  wire               reset_n,
   countdown_timer_if.slave  bus
);

   localparam int                  c_AW        = $clog2(ALARM_SECS + 1);
   localparam logic [SUB_WIDTH-1:0] c_SUB_MAX  = SUB_WIDTH'(TICKS_PER_SEC - 1);
   localparam logic [c_AW-1:0]      c_ASEC_MAX = c_AW'(ALARM_SECS - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUNNING = 2'd1,
      S_PAUSED  = 2'd2,
      S_ALARM   = 2'd3
   } state_t;

   state_t               r_state;
   logic [7:0]           r_min;
   logic [7:0]           r_sec;
   logic [SUB_WIDTH-1:0] r_sub;
   logic [c_AW-1:0]      r_asec;
   logic                 r_done;

   logic [7:0] w_dec_min;
   logic [7:0] w_dec_sec;
   logic [7:0] w_ld_min;
   logic [7:0] w_ld_sec;
   logic       w_time_zero;
   logic       w_time_last;

   function automatic logic [3:0] f_clamp(input logic [3:0] d, input logic [3:0] mx);
      return (d > mx) ? mx : d;
   endfunction

   assign w_ld_min    = {f_clamp(bus.load_min[7:4], 4'd9), f_clamp(bus.load_min[3:0], 4'd9)};
   assign w_ld_sec    = {f_clamp(bus.load_sec[7:4], 4'd5), f_clamp(bus.load_sec[3:0], 4'd9)};
   assign w_time_zero = (r_min == 8'h00) && (r_sec == 8'h00);
   assign w_time_last = (r_min == 8'h00) && (r_sec == 8'h01);

   // One-second BCD decrement with the borrow rippling sec units -> min tens
   always_comb begin
      w_dec_min = r_min;
      w_dec_sec = r_sec;
      if (r_sec[3:0] != 4'd0) begin
         w_dec_sec[3:0] = r_sec[3:0] - 4'd1;
      end else begin
         w_dec_sec[3:0] = 4'd9;
         if (r_sec[7:4] != 4'd0) begin
            w_dec_sec[7:4] = r_sec[7:4] - 4'd1;
         end else begin
            w_dec_sec[7:4] = 4'd5;
            if (r_min[3:0] != 4'd0) begin
               w_dec_min[3:0] = r_min[3:0] - 4'd1;
            end else begin
               w_dec_min[3:0] = 4'd9;
               w_dec_min[7:4] = r_min[7:4] - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_min   <= 8'h00;
         r_sec   <= 8'h00;
         r_sub   <= '0;
         r_asec  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.clear) begin
            r_state <= S_IDLE;
            r_min   <= 8'h00;
            r_sec   <= 8'h00;
            r_sub   <= '0;
            r_asec  <= '0;
         end else if (bus.start_stop) begin
            // Any tick arriving alongside a start_stop is dropped here
            case (r_state)
               S_IDLE: begin
                  if (!w_time_zero) begin
                     r_state <= S_RUNNING;
                     r_sub   <= c_SUB_MAX;
                  end
               end
               S_RUNNING: r_state <= S_PAUSED;
               S_PAUSED:  r_state <= S_RUNNING;
               S_ALARM:   r_state <= S_IDLE;
               default:   r_state <= S_IDLE;
            endcase
         end else if (bus.load && (r_state == S_IDLE || r_state == S_PAUSED)) begin
            r_min <= w_ld_min;
            r_sec <= w_ld_sec;
         end else if (bus.tick) begin
            case (r_state)
               S_RUNNING: begin
                  if (r_sub != '0) begin
                     r_sub <= r_sub - 1'b1;
                  end else begin
                     r_sub <= c_SUB_MAX;
                     r_min <= w_dec_min;
                     r_sec <= w_dec_sec;
                     if (w_time_last) begin
                        r_state <= S_ALARM;
                        r_done  <= 1'b1;
                        r_asec  <= c_ASEC_MAX;
                     end
                  end
               end
               S_ALARM: begin
                  if (r_sub != '0) begin
                     r_sub <= r_sub - 1'b1;
                  end else begin
                     r_sub <= c_SUB_MAX;
                     if (r_asec == '0) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_asec <= r_asec - 1'b1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign bus.min_bcd = r_min;
   assign bus.sec_bcd = r_sec;
   assign bus.running = (r_state == S_RUNNING);
   assign bus.alarm   = (r_state == S_ALARM);
   assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Directed self-checking bench for countdown_timer (2 ticks/s,
//               3 s alarm).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_err;
   int   done_cnt;

   countdown_timer_if bus ();

   countdown_timer #(
      .TICKS_PER_SEC (2),
      .SUB_WIDTH     (4),
      .ALARM_SECS    (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic t, input logic ld, input logic ss, input logic clr);
      bus.tick       = t;
      bus.load       = ld;
      bus.start_stop = ss;
      bus.clear      = clr;
      @(posedge clk);
      #1;
      bus.tick       = 1'b0;
      bus.load       = 1'b0;
      bus.start_stop = 1'b0;
      bus.clear      = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] m, input logic [7:0] s);
      bus.load_min = m;
      bus.load_sec = s;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_time(input string tag, input logic [7:0] m, input logic [7:0] s);
      chk({tag, "_min"}, {24'd0, bus.min_bcd}, {24'd0, m});
      chk({tag, "_sec"}, {24'd0, bus.sec_bcd}, {24'd0, s});
   endtask

   initial begin
      n_cmp = 0; n_err = 0; done_cnt = 0;
      reset_n = 1'b0;
      bus.tick = 1'b0; bus.load = 1'b0; bus.start_stop = 1'b0; bus.clear = 1'b0;
      bus.load_min = 8'h00; bus.load_sec = 8'h00;
      @(posedge clk); @(posedge clk); #1;
      chk_time("reset", 8'h00, 8'h00);
      chk("reset_running", {31'd0, bus.running}, 32'd0);
      chk("reset_alarm",   {31'd0, bus.alarm},   32'd0);
      chk("reset_done",    {31'd0, bus.done},    32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Borrow chain
      do_load(8'h10, 8'h00);
      chk_time("load_10_00", 8'h10, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("start_running", {31'd0, bus.running}, 32'd1);
      ticks(2);
      chk_time("borrow_09_59", 8'h09, 8'h59);
      ticks(2);
      chk_time("dec_09_58", 8'h09, 8'h58);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk_time("clear_time", 8'h00, 8'h00);
      chk("clear_running", {31'd0, bus.running}, 32'd0);
      do_load(8'h01, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      ticks(2);
      chk_time("borrow_00_59", 8'h00, 8'h59);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // Expiry and timed alarm
      done_cnt = 0;
      do_load(8'h00, 8'h01);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      ticks(1);
      chk_time("pre_expiry", 8'h00, 8'h01);
      chk("pre_expiry_done", {31'd0, bus.done}, 32'd0);
      ticks(1);
      chk_time("expiry", 8'h00, 8'h00);
      chk("expiry_done",    {31'd0, bus.done},    32'd1);
      chk("expiry_alarm",   {31'd0, bus.alarm},   32'd1);
      chk("expiry_running", {31'd0, bus.running}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
      ticks(5);
      chk("alarm_after_5", {31'd0, bus.alarm}, 32'd1);
      ticks(1);
      chk("alarm_after_6", {31'd0, bus.alarm}, 32'd0);
      chk("idle_after_alarm", {31'd0, bus.running}, 32'd0);
      ticks(4);
      chk("done_pulse_count", done_cnt, 32'd1);

      // Pause / resume, tick dropped on the pause cycle
      do_load(8'h00, 8'h05);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      ticks(1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("paused_running", {31'd0, bus.running}, 32'd0);
      chk_time("paused_hold", 8'h00, 8'h05);
      ticks(5);
      chk_time("paused_ticks", 8'h00, 8'h05);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("resume_running", {31'd0, bus.running}, 32'd1);
      ticks(1);
      chk_time("resume_dec", 8'h00, 8'h04);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // Clamping, ignored load, start at zero
      do_load(8'hAF, 8'h7C);
      chk_time("clamp", 8'h99, 8'h59);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      do_load(8'h00, 8'h30);
      chk_time("load_ignored", 8'h99, 8'h59);
      chk("load_ignored_run", {31'd0, bus.running}, 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("start_at_zero", {31'd0, bus.running}, 32'd0);
      chk_time("start_at_zero", 8'h00, 8'h00);

      // Priority and acknowledge
      do_load(8'h00, 8'h03);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      bus.load_min = 8'h00; bus.load_sec = 8'h40;
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      chk_time("prio_clear", 8'h00, 8'h00);
      chk("prio_running", {31'd0, bus.running}, 32'd0);
      do_load(8'h00, 8'h01);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      ticks(2);
      chk("ack_pre_alarm", {31'd0, bus.alarm}, 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("ack_alarm", {31'd0, bus.alarm}, 32'd0);
      chk("ack_running", {31'd0, bus.running}, 32'd0);
      chk_time("ack_time", 8'h00, 8'h00);

      // Asynchronous reset in the middle of a run
      do_load(8'h05, 8'h30);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      ticks(3);
      chk_time("midrun", 8'h05, 8'h29);
      #3;
      reset_n = 1'b0;
      #1;
      chk_time("async_reset", 8'h00, 8'h00);
      chk("async_reset_running", {31'd0, bus.running}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
